xgriscv_memarb: RTL

Single-port memory arbiter and sequencer for the xgriscv pipeline. Shares one unified, variable-latency memory port between instruction fetch (F stage) and load/store (M stage). Freezes the pipeline with `stall` until the current cycle's fetch and data accesses have both completed. Sits between the datapath's `pcF`/`instrF` and `aluoutM`/`writedataM`/`readdataM` ports and the external memory.

---
 rtl/xgriscv_memarb.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/xgriscv_memarb.sv
// xgriscv_memarb: shares one variable-latency memory port between instruction
// fetch (F) and load/store (M). The pipeline is stalled until both accesses
// for the current cycle have completed. Data goes first because it belongs to
// the older instruction.
// Optional: define XGRISCV_MEMARB_PREFETCH_EN for a one-entry next-line
// prefetch buffer (pbuf/ptag/pvalid).
module xgriscv_memarb #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pcF,
  output logic [DW-1:0] instrF,
  output logic          ivalidF,
  input  logic          dreqM,
  input  logic          memwriteM,
  input  logic [AW-1:0] aluoutM,
  input  logic [DW-1:0] writedataM,
  input  logic [3:0]    ampM,
  output logic [DW-1:0] readdataM,
  output logic          dvalidM,
  output logic          stall,
  output logic [AW-1:0] maddr,
  output logic [DW-1:0] mwdata,
  output logic          mwe,
  output logic [3:0]    mamp,
  output logic          mreq,
  input  logic [DW-1:0] mrdata,
  input  logic          mready
);

  // PACC is only reachable when the prefetch buffer is built in
  typedef enum logic [1:0] {IDLE, DACC, FACC, PACC} state_t;

  state_t state, stateNext;
  logic   ihave, dhave;
  logic   dneed;

  assign dneed   = dreqM & ~dhave;
  assign stall   = dneed | ~ihave;
  assign ivalidF = ihave;
  assign dvalidM = dhave;
  // Derived from state so that reset drops the request immediately
  assign mreq    = (state != IDLE);

`ifdef XGRISCV_MEMARB_PREFETCH_EN
  logic [DW-1:0] pbuf;
  logic [AW-3:0] ptag;
  logic          pvalid;
  logic [AW-3:0] pnext;
  logic          pmatch, storeKill, phit;

  assign pnext     = pcF[AW-1:2] + {{(AW-3){1'b0}}, 1'b1};
  assign pmatch    = (pcF[AW-1:2] == ptag);
  // A store from the older instruction to the buffered word must win over a hit
  assign storeKill = (state == IDLE) & dneed & memwriteM & (aluoutM[AW-1:2] == ptag);
  assign phit      = ~ihave & pvalid & pmatch & ~storeKill;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state: data first, then fetch; outstanding requests wait for mready
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (dneed) stateNext = DACC;
`ifdef XGRISCV_MEMARB_PREFETCH_EN
        else if (~ihave & ~phit) stateNext = FACC;
        else if (ihave & ~pvalid) stateNext = PACC;
`else
        else if (~ihave) stateNext = FACC;
`endif
      end
      DACC, FACC, PACC: if (mready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Capture the request on leaving IDLE; held until completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      maddr  <= '0;
      mwdata <= '0;
      mwe    <= 1'b0;
      mamp   <= 4'b0000;
    end else if (state == IDLE) begin
      if (stateNext == DACC) begin
        maddr  <= aluoutM;
        mwdata <= writedataM;
        mwe    <= memwriteM;
        mamp   <= ampM;
      end else if (stateNext == FACC) begin
        maddr  <= {pcF[AW-1:2], 2'b00};
        mwe    <= 1'b0;
        mamp   <= 4'b1111;
      end
`ifdef XGRISCV_MEMARB_PREFETCH_EN
      else if (stateNext == PACC) begin
        maddr  <= {pnext, 2'b00};
        mwe    <= 1'b0;
        mamp   <= 4'b1111;
      end
`endif
    end
  end

  // Completion flags and returned data; flags clear when the pipeline advances
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ihave     <= 1'b0;
      dhave     <= 1'b0;
      instrF    <= '0;
      readdataM <= '0;
`ifdef XGRISCV_MEMARB_PREFETCH_EN
      pbuf      <= '0;
      ptag      <= '0;
      pvalid    <= 1'b0;
`endif
    end else begin
      if (!stall) begin
        ihave <= 1'b0;
        dhave <= 1'b0;
      end
      if (state == DACC && mready) begin
        dhave <= 1'b1;
        if (!mwe) readdataM <= mrdata;
      end
      if (state == FACC && mready) begin
        ihave  <= 1'b1;
        instrF <= mrdata;
      end
`ifdef XGRISCV_MEMARB_PREFETCH_EN
      if (phit) begin
        instrF <= pbuf;
        ihave  <= 1'b1;
        pvalid <= 1'b0;
      end else if (~ihave & pvalid & ~pmatch) begin
        pvalid <= 1'b0;
      end
      if (state == PACC && mready) begin
        // Late prefetch for the word already being waited on goes straight in
        if (~ihave & pmatch) begin
          instrF <= mrdata;
          ihave  <= 1'b1;
        end else begin
          pbuf   <= mrdata;
          pvalid <= 1'b1;
        end
      end
      if (state == IDLE && stateNext == PACC) ptag <= pnext;
      if (storeKill) pvalid <= 1'b0;
`endif
    end
  end

endmodule
